// File: rtl/async_read_mem.sv
// rtl/async_read_mem.sv - register-file memory, synchronous write, combinational read, per-word valid bits
// Optional write-through view of the addressed word: define ASYNC_MEM_WRITE_BYPASS_EN.
module async_read_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             writeEnable,
    input  logic [DEPTH-1:0] address,
    input  logic [WIDTH-1:0] writeData,
    output logic [WIDTH-1:0] readData,
    output logic             readValid
);

    localparam int WORDS = 1 << DEPTH;

    logic [WIDTH-1:0] mem_q [WORDS];
    logic [WORDS-1:0] valid_q;
    logic [WORDS-1:0] valid_d;

    // Full clear on reset is why this stays a register array rather than a RAM macro.
    always_comb begin
        valid_d = valid_q;
        if (writeEnable) begin
            valid_d[address] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (writeEnable) begin
                mem_q[address] <= writeData;
            end
        end
    end

`ifdef ASYNC_MEM_WRITE_BYPASS_EN
    always_comb begin
        readData  = mem_q[address];
        readValid = valid_q[address];
        if (writeEnable && !reset) begin
            readData  = writeData;
            readValid = 1'b1;
        end
    end
`else
    always_comb begin
        readData  = mem_q[address];
        readValid = valid_q[address];
    end
`endif

endmodule

// File: tb/tb_async_read_mem.sv
// tb/tb_async_read_mem.sv - directed scoreboard bench for async_read_mem
module tb_async_read_mem;

    logic       clk;
    logic       reset;
    logic       writeEnable;
    logic [3:0] address;
    logic [7:0] writeData;
    logic [7:0] readData;
    logic       readValid;

    typedef struct packed {
        logic [7:0] d;
        logic       v;
    } exp_t;

    exp_t sb[$];
    int   vectors;
    int   miscompares;

    async_read_mem #(.DEPTH(4), .WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .writeEnable (writeEnable),
        .address     (address),
        .writeData   (writeData),
        .readData    (readData),
        .readValid   (readValid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            vectors++;
            assert (readData === e.d && readValid === e.v) else begin
                miscompares++;
                $error("FAIL %s: got %h/%b expected %h/%b", tag, readData, readValid, e.d, e.v);
            end
        end
    endtask

    task automatic rd(input logic [3:0] a, input logic [7:0] d, input logic v, input string tag);
        address = a;
        sb.push_back('{d: d, v: v});
        #1;
        check(tag);
    endtask

    task automatic expect_now(input logic [7:0] d, input logic v, input string tag);
        sb.push_back('{d: d, v: v});
        #1;
        check(tag);
    endtask

    initial begin
        logic [7:0] toggles [3];
        vectors     = 0;
        miscompares = 0;
        clk         = 0;
        reset       = 1;
        writeEnable = 0;
        address     = 0;
        writeData   = 0;
        toggles[0]  = 8'h01;
        toggles[1]  = 8'hFF;
        toggles[2]  = 8'h00;

        rd(4'd0, 8'h00, 1'b0, "reset_addr0");
        for (int a = 0; a < 16; a++) begin
            rd(a[3:0], 8'h00, 1'b0, "reset_sweep");
        end

        @(negedge clk);
        reset   = 0;
        address = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            writeData = toggles[i];
            @(posedge clk);
            expect_now(8'h00, 1'b0, "we0_toggle");
        end

        @(negedge clk);
        writeEnable = 1;
        writeData   = 8'h00;
        @(posedge clk);
        expect_now(8'h00, 1'b1, "write_zero");
        @(negedge clk);
        writeData = 8'hFF;
        @(posedge clk);
        expect_now(8'hFF, 1'b1, "write_ff");
        @(negedge clk);
        writeEnable = 0;
        writeData   = 8'h00;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            expect_now(8'hFF, 1'b1, "hold_ff");
        end

        @(negedge clk);
        writeEnable = 1;
        address     = 4'd3;
        writeData   = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        address   = 4'd15;
        writeData = 8'h5A;
        @(posedge clk);
        @(negedge clk);
        writeEnable = 0;
        writeData   = 8'h00;
        rd(4'd3,  8'hA5, 1'b1, "sweep_a3");
        rd(4'd15, 8'h5A, 1'b1, "sweep_a15");
        rd(4'd0,  8'hFF, 1'b1, "sweep_a0");
        rd(4'd7,  8'h00, 1'b0, "sweep_a7");

        @(negedge clk);
        writeEnable = 1;
        writeData   = 8'h3C;
`ifdef ASYNC_MEM_WRITE_BYPASS_EN
        rd(4'd3, 8'h3C, 1'b1, "rdw_before_edge");
`else
        rd(4'd3, 8'hA5, 1'b1, "rdw_before_edge");
`endif
        @(posedge clk);
        expect_now(8'h3C, 1'b1, "rdw_after_edge");
        @(negedge clk);
        writeEnable = 0;
        rd(4'd3, 8'h3C, 1'b1, "rdw_committed");

        #2;
        reset = 1;
        rd(4'd3,  8'h00, 1'b0, "midcycle_reset_a3");
        rd(4'd15, 8'h00, 1'b0, "midcycle_reset_a15");
        writeEnable = 1;
        writeData   = 8'h77;
        rd(4'd5, 8'h00, 1'b0, "we_during_reset");
        @(posedge clk);
        expect_now(8'h00, 1'b0, "edge_during_reset");
        @(negedge clk);
        writeEnable = 0;
        reset       = 0;
        rd(4'd5, 8'h00, 1'b0, "after_release_a5");

        @(negedge clk);
        writeEnable = 1;
        address     = 4'd9;
        writeData   = 8'h42;
        @(posedge clk);
        @(negedge clk);
        writeEnable = 0;
        rd(4'd9, 8'h42, 1'b1, "post_reset_write");
        rd(4'd3, 8'h00, 1'b0, "post_reset_a3");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
